// File: rtl/bpsk_demod.sv
// Coherent BPSK demodulator: correlates rx_in against carrier (0,+1,0,-1) over N samples per bit, frames FRAME_LEN bits.
// Latency: bit_valid/bit_out register on the edge consuming the N-th sample of a bit; frame_valid on the FRAME_LEN-th bit_valid.
// Backpressure: none; ce=0 freezes all state, output pulses are single-clk and never stretched.
//
// Ports: clk, reset (async, active-high), ce (sample strobe), sync (phase-0 / bit-0 alignment),
//        rx_in (10-bit signed), bit_out/bit_valid/bit_erase, frame_out/frame_valid/frame_err.
// Optional feature: define BPSK_DEMOD_ERASURE_EN to generate erasure flags (|acc| < THRESH);
//        otherwise bit_erase and frame_err are tied low.
module bpsk_demod #(
  parameter int N         = 8,
  parameter int FRAME_LEN = 7,
  parameter int THRESH    = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 sync,
  input  logic signed [9:0]    rx_in,
  output logic                 bit_out,
  output logic                 bit_valid,
  output logic                 bit_erase,
  output logic [FRAME_LEN-1:0] frame_out,
  output logic                 frame_valid,
  output logic                 frame_err
);

  localparam int ACC_W = 10 + $clog2(N);
  localparam int SW    = $clog2(N);
  localparam int BW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [SW-1:0] LAST_S = SW'(N - 1);
  localparam logic [BW-1:0] LAST_B = BW'(FRAME_LEN - 1);

  if (N < 4 || (N % 4) != 0) begin : g_bad_n
    $error("bpsk_demod: N must be a multiple of 4 and at least 4");
  end
  if (THRESH < 1) begin : g_bad_thresh
    $error("bpsk_demod: THRESH must be positive");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state;
  logic [1:0]              phase;
  logic [SW-1:0]           samp_cnt;
  logic [BW-1:0]           bit_cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] rx_ext;
  logic [FRAME_LEN-1:0]    frame_buf;
  logic [FRAME_LEN-1:0]    frame_next;
  logic                    dec;
  logic                    resync;
  logic                    sample_en;
  logic                    bit_end;
  logic                    frame_end;

  // sync always wins over a coincident bit/frame boundary
  assign resync    = ce && sync;
  assign sample_en = ce && !sync && (state == RUN);
  assign bit_end   = sample_en && (samp_cnt == LAST_S);
  assign frame_end = bit_end && (bit_cnt == LAST_B);

  // Accumulator including the current sample, so the decision sees all N samples
  always_comb begin
    rx_ext   = {{(ACC_W-10){rx_in[9]}}, rx_in};
    acc_next = acc;
    case (phase)
      2'd1:    acc_next = acc + rx_ext;
      2'd3:    acc_next = acc - rx_ext;
      default: acc_next = acc;
    endcase
    dec                 = ~acc_next[ACC_W-1];
    frame_next          = frame_buf;
    frame_next[bit_cnt] = dec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      phase       <= 2'd0;
      samp_cnt    <= '0;
      bit_cnt     <= '0;
      acc         <= '0;
      frame_buf   <= '0;
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
      frame_out   <= '0;
      frame_valid <= 1'b0;
    end else begin
      bit_valid   <= 1'b0;
      frame_valid <= 1'b0;
      if (resync) begin
        // The sync sample is phase 0 of bit 0: it contributes zero and advances the counters.
        state     <= RUN;
        phase     <= 2'd1;
        samp_cnt  <= SW'(1);
        bit_cnt   <= '0;
        acc       <= '0;
        frame_buf <= '0;
      end else if (sample_en) begin
        phase    <= phase + 2'd1;
        acc      <= acc_next;
        samp_cnt <= samp_cnt + SW'(1);
        if (bit_end) begin
          acc       <= '0;
          samp_cnt  <= '0;
          bit_out   <= dec;
          bit_valid <= 1'b1;
          frame_buf <= frame_next;
          if (bit_cnt == LAST_B) begin
            bit_cnt     <= '0;
            frame_out   <= frame_next;
            frame_valid <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
      end
    end
  end

`ifdef BPSK_DEMOD_ERASURE_EN
  logic signed [31:0] acc_ext;
  logic               erase_now;
  logic               err_sticky;

  assign acc_ext   = {{(32-ACC_W){acc_next[ACC_W-1]}}, acc_next};
  assign erase_now = (acc_ext < THRESH) && (acc_ext > -THRESH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_erase  <= 1'b0;
      frame_err  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      bit_erase <= 1'b0;
      frame_err <= 1'b0;
      if (resync) begin
        err_sticky <= 1'b0;
      end else if (bit_end) begin
        bit_erase <= erase_now;
        if (frame_end) begin
          frame_err  <= err_sticky | erase_now;
          err_sticky <= 1'b0;
        end else begin
          err_sticky <= err_sticky | erase_now;
        end
      end
    end
  end
`else
  assign bit_erase = 1'b0;
  assign frame_err = 1'b0;
`endif

endmodule
